ahb_param_arbiter: RTL and testbench

Parametrised AHB bus arbiter for up to 16 masters, successor to the fixed 16-master arbiter. It selects round-robin or fixed-priority arbitration, honours locked transfers, tracks SPLIT-masked masters internally, and always drives a one-hot grant, falling back to a default master when nobody requests. It sits between the master request lines and the address/data muxes, which it steers via HMASTER.

---
 rtl/ahb_arb_pkg.sv | 27 ++
 rtl/ahb_arb_select.sv | 33 +++
 rtl/ahb_param_arbiter.sv | 120 ++++++++++++
 tb/tb_ahb_param_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the parametrised AHB arbiter: response encodings,
// master-count limit and one-hot to index conversion.
package ahb_arb_pkg;

   localparam int MAX_MASTERS = 16;
   localparam int IDX_W       = 4;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   // OR-reduction of set-bit positions; exact for one-hot inputs.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_MASTERS; i++) begin
         if (vec[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ahb_arb_select.sv
// Combinational rotate-priority pick: first set bit of eligible searching
// upward from ptr+1 (wrapping). ptr = NUM_MASTERS-1 yields lowest-index-wins.
module ahb_arb_select
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 16,
   parameter int MW          = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] eligible,
   input  logic [MW-1:0]          ptr,
   output logic [NUM_MASTERS-1:0] pick,
   output logic                   found
);

   logic [MW:0] cand;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand = {1'b0, ptr} + (MW+1)'(i);
         if (cand >= (MW+1)'(NUM_MASTERS)) begin
            cand = cand - (MW+1)'(NUM_MASTERS);
         end
         if (!found && eligible[cand[MW-1:0]]) begin
            pick[cand[MW-1:0]] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_param_arbiter.sv
// Parametrised AHB arbiter: round-robin or fixed priority, locked-transfer
// hold, internal SPLIT masking and a default master fallback.
module ahb_param_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 16,
   parameter int DEFAULT_MASTER = 0,
   parameter int ROUND_ROBIN    = 1,
   parameter int MW             = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQx,
   input  logic [NUM_MASTERS-1:0] HLOCKx,
   input  logic [NUM_MASTERS-1:0] HSPLIT,
   input  logic                   HREADY,
   input  logic [1:0]             HRESP,
   output logic [NUM_MASTERS-1:0] HGRANTx,
   output logic [MW-1:0]          HMASTER,
   output logic                   HMASTLOCK
);

   localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
   localparam logic [MW-1:0]          DEFAULT_IDX   = MW'(DEFAULT_MASTER);

   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [MW-1:0]          hmaster_q, hmaster_d;
   logic                   hmastlock_q, hmastlock_d;
   logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
   logic [MW-1:0]          rr_ptr_q, rr_ptr_d;

   logic [MAX_MASTERS-1:0] grant_wide, pick_wide;
   logic [IDX_W-1:0]       owner_full, pick_full;
   logic [MW-1:0]          owner_idx, pick_idx, sel_ptr;
   logic [NUM_MASTERS-1:0] eligible, pick;
   logic                   found, hold;

   always_comb begin
      grant_wide                    = '0;
      grant_wide[NUM_MASTERS-1:0]   = grant_q;
      pick_wide                     = '0;
      pick_wide[NUM_MASTERS-1:0]    = pick;
      owner_full                    = onehot_to_idx(grant_wide);
      pick_full                     = onehot_to_idx(pick_wide);
      owner_idx                     = owner_full[MW-1:0];
      pick_idx                      = pick_full[MW-1:0];
   end

   // Eligibility uses the post-edge mask, so a split owner loses the bus at the
   // same edge and an HSPLIT resume is granted at the edge it is sampled.
   always_comb begin
      split_mask_d = split_mask_q;
      if (HREADY && (HRESP == HRESP_SPLIT)) begin
         split_mask_d[hmaster_q] = 1'b1;
      end
      split_mask_d = split_mask_d & ~HSPLIT;
   end

   assign eligible = HBUSREQx & ~split_mask_d;
   assign hold     = HLOCKx[owner_idx] & HBUSREQx[owner_idx];
   assign sel_ptr  = (ROUND_ROBIN != 0) ? rr_ptr_q : MW'(NUM_MASTERS - 1);

   ahb_arb_select #(
      .NUM_MASTERS (NUM_MASTERS),
      .MW          (MW)
   ) u_select (
      .eligible (eligible),
      .ptr      (sel_ptr),
      .pick     (pick),
      .found    (found)
   );

   always_comb begin
      grant_d     = grant_q;
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
      rr_ptr_d    = rr_ptr_q;
      if (HREADY) begin
         hmaster_d   = owner_idx;
         hmastlock_d = HLOCKx[owner_idx];
         if (hold) begin
            rr_ptr_d = owner_idx;
         end else if (found) begin
            grant_d  = pick;
            rr_ptr_d = pick_idx;
         end else begin
            grant_d  = DEFAULT_GRANT;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         grant_q      <= DEFAULT_GRANT;
         hmaster_q    <= DEFAULT_IDX;
         hmastlock_q  <= 1'b0;
         split_mask_q <= '0;
         rr_ptr_q     <= DEFAULT_IDX;
      end else begin
         grant_q      <= grant_d;
         hmaster_q    <= hmaster_d;
         hmastlock_q  <= hmastlock_d;
         split_mask_q <= split_mask_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign HGRANTx   = grant_q;
   assign HMASTER   = hmaster_q;
   assign HMASTLOCK = hmastlock_q;

   always @(posedge HCLK) begin
      if (HRESETn) begin
         assert ($onehot(grant_q));
         assert (int'(hmaster_q) < NUM_MASTERS);
         assert ((grant_q & split_mask_q & ~DEFAULT_GRANT) == '0);
      end
   end

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// Scoreboard bench for ahb_param_arbiter: a round-robin instance and a
// fixed-priority instance share stimulus; expectations are queued per edge.
module tb_ahb_param_arbiter;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic [15:0] hbusreq, hlock, hsplit;
   logic        hready;
   logic [1:0]  hresp;
   logic [15:0] grant_rr, grant_fp;
   logic [3:0]  master_rr, master_fp;
   logic        lock_rr, lock_fp;

   typedef struct packed {
      logic [15:0] grant;
      logic [3:0]  master;
      logic        lock;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 hclk = ~hclk;

   ahb_param_arbiter #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)) dut (
      .HCLK(hclk), .HRESETn(hresetn), .HBUSREQx(hbusreq), .HLOCKx(hlock),
      .HSPLIT(hsplit), .HREADY(hready), .HRESP(hresp),
      .HGRANTx(grant_rr), .HMASTER(master_rr), .HMASTLOCK(lock_rr)
   );

   ahb_param_arbiter #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .ROUND_ROBIN(0)) dut_fp (
      .HCLK(hclk), .HRESETn(hresetn), .HBUSREQx(hbusreq), .HLOCKx(hlock),
      .HSPLIT(hsplit), .HREADY(hready), .HRESP(hresp),
      .HGRANTx(grant_fp), .HMASTER(master_fp), .HMASTLOCK(lock_fp)
   );

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic push(input logic [15:0] g, input logic [3:0] m, input logic l);
      sb_q.push_back({g, m, l});
   endtask

   task automatic apply_reset();
      hresetn = 1'b0;
      hbusreq = '0;
      hlock   = '0;
      hsplit  = '0;
      hresp   = 2'b00;
      hready  = 1'b1;
      tick();
      hresetn = 1'b1;
   endtask

   task automatic test_reset();
      exp_t got, exp;
      hresetn = 1'b1;
      hbusreq = '0; hlock = '0; hsplit = '0; hresp = 2'b00; hready = 1'b1;
      #2 hresetn = 1'b0;
      #1;
      got = {grant_rr, master_rr, lock_rr};
      exp = {16'h0001, 4'd0, 1'b0};
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL reset_async got=%h want=%h", got, exp);
      end else $display("ok   reset_async state=%h", got);
      n_cmp++;
      if (dut.split_mask_q !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_mask got=%h want=0000", dut.split_mask_q);
      end else $display("ok   reset_mask");
      tick();
      hresetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(16'h0001, 4'd0, 1'b0);
         tick();
         exp = sb_q.pop_front();
         got = {grant_rr, master_rr, lock_rr};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL idle_%0d grant=%h master=%0d lock=%b want grant=%h master=%0d lock=%b",
                     i, got.grant, got.master, got.lock, exp.grant, exp.master, exp.lock);
         end else $display("ok   idle_%0d grant=%h", i, got.grant);
      end
   endtask

   task automatic test_round_robin();
      exp_t got, exp;
      logic [15:0] eg [9] = '{16'h0002, 16'h0004, 16'h0008, 16'h0002, 16'h0004,
                              16'h0004, 16'h0004, 16'h0004, 16'h0008};
      logic [3:0]  em [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
      apply_reset();
      hbusreq = 16'h000E;
      for (int i = 0; i < 9; i++) begin
         hready  = (i >= 5 && i <= 7) ? 1'b0 : 1'b1;
         hbusreq = (i >= 5 && i <= 7) ? 16'h0008 : 16'h000E;
         push(eg[i], em[i], 1'b0);
         tick();
         exp = sb_q.pop_front();
         got = {grant_rr, master_rr, lock_rr};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL rr_%0d grant=%h master=%0d lock=%b want grant=%h master=%0d lock=%b",
                     i, got.grant, got.master, got.lock, exp.grant, exp.master, exp.lock);
         end else $display("ok   rr_%0d grant=%h master=%0d hready=%b", i, got.grant, got.master, hready);
      end
      hready = 1'b1;
   endtask

   task automatic test_fixed_priority();
      exp_t got, exp;
      logic [15:0] eg [5] = '{16'h0002, 16'h0002, 16'h0002, 16'h0010, 16'h0010};
      logic [3:0]  em [5] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd4};
      logic [15:0] rg [5] = '{16'h0002, 16'h0010, 16'h0002, 16'h0010, 16'h0010};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         hbusreq = (i < 3) ? 16'h0012 : 16'h0010;
         push(eg[i], em[i], 1'b0);
         tick();
         exp = sb_q.pop_front();
         got = {grant_fp, master_fp, lock_fp};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL fp_%0d grant=%h master=%0d lock=%b want grant=%h master=%0d lock=%b",
                     i, got.grant, got.master, got.lock, exp.grant, exp.master, exp.lock);
         end else $display("ok   fp_%0d grant=%h master=%0d", i, got.grant, got.master);
         n_cmp++;
         if (grant_rr !== rg[i]) begin
            n_err++;
            $display("FAIL fp_rr_contrast_%0d grant=%h want=%h", i, grant_rr, rg[i]);
         end else $display("ok   fp_rr_contrast_%0d grant=%h", i, grant_rr);
      end
   endtask

   task automatic test_lock();
      exp_t got, exp;
      apply_reset();
      hbusreq = 16'h0008;
      hlock   = 16'h0008;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) hbusreq = 16'h00FF;
         if (i == 6) hlock   = 16'h0000;
         if (i == 0)      push(16'h0008, 4'd0, 1'b0);
         else if (i < 6)  push(16'h0008, 4'd3, 1'b1);
         else if (i == 6) push(16'h0010, 4'd3, 1'b0);
         else             push(16'h0020, 4'd4, 1'b0);
         tick();
         exp = sb_q.pop_front();
         got = {grant_rr, master_rr, lock_rr};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL lock_%0d grant=%h master=%0d lock=%b want grant=%h master=%0d lock=%b",
                     i, got.grant, got.master, got.lock, exp.grant, exp.master, exp.lock);
         end else $display("ok   lock_%0d grant=%h master=%0d mastlock=%b", i, got.grant, got.master, got.lock);
      end
   endtask

   task automatic test_split();
      exp_t got, exp;
      logic [1:0]  rsp [11] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3};
      logic [15:0] spl [11] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h0, 16'h0, 16'h4, 16'h0, 16'h0, 16'h4};
      logic        rdy [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [15:0] eg  [11] = '{16'h4, 16'h4, 16'h1, 16'h1, 16'h4, 16'h4, 16'h1, 16'h1, 16'h4, 16'h4, 16'h4};
      logic [3:0]  em  [11] = '{4'd0, 4'd2, 4'd2, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd0, 4'd2, 4'd2};
      logic [15:0] emk [11] = '{16'h0, 16'h0, 16'h4, 16'h4, 16'h0, 16'h0, 16'h4, 16'h0, 16'h0, 16'h0, 16'h0};
      apply_reset();
      hbusreq = 16'h0004;
      for (int i = 0; i < 11; i++) begin
         hresp  = rsp[i];
         hsplit = spl[i];
         hready = rdy[i];
         push(eg[i], em[i], 1'b0);
         tick();
         exp = sb_q.pop_front();
         got = {grant_rr, master_rr, lock_rr};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL split_%0d grant=%h master=%0d lock=%b want grant=%h master=%0d lock=%b",
                     i, got.grant, got.master, got.lock, exp.grant, exp.master, exp.lock);
         end else $display("ok   split_%0d grant=%h master=%0d", i, got.grant, got.master);
         n_cmp++;
         if (dut.split_mask_q !== emk[i]) begin
            n_err++;
            $display("FAIL split_mask_%0d got=%h want=%h", i, dut.split_mask_q, emk[i]);
         end else $display("ok   split_mask_%0d mask=%h", i, dut.split_mask_q);
      end
      hresp  = 2'b00;
      hsplit = '0;
      hready = 1'b1;
   endtask

   task automatic test_reset_mid();
      exp_t got, exp;
      logic [15:0] eg [5] = '{16'h4, 16'h4, 16'h8, 16'h8, 16'h8};
      logic [3:0]  em [5] = '{4'd0, 4'd2, 4'd2, 4'd3, 4'd3};
      logic        el [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      apply_reset();
      hbusreq = 16'h0004;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin hbusreq = 16'h000C; hlock = 16'h0008; hresp = 2'b11; end
         if (i == 3) hresp  = 2'b00;
         if (i == 4) hready = 1'b0;
         push(eg[i], em[i], el[i]);
         tick();
         exp = sb_q.pop_front();
         got = {grant_rr, master_rr, lock_rr};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL mid_%0d grant=%h master=%0d lock=%b want grant=%h master=%0d lock=%b",
                     i, got.grant, got.master, got.lock, exp.grant, exp.master, exp.lock);
         end else $display("ok   mid_%0d grant=%h master=%0d mastlock=%b", i, got.grant, got.master, got.lock);
      end
      #3 hresetn = 1'b0;
      #1;
      got = {grant_rr, master_rr, lock_rr};
      exp = {16'h0001, 4'd0, 1'b0};
      n_cmp++;
      if (got !== exp || dut.split_mask_q !== 16'h0 || dut.rr_ptr_q !== 4'd0) begin
         n_err++;
         $display("FAIL mid_reset state=%h mask=%h ptr=%0d want state=%h mask=0000 ptr=0",
                  got, dut.split_mask_q, dut.rr_ptr_q, exp);
      end else $display("ok   mid_reset state=%h", got);
      hbusreq = '0; hlock = '0; hresp = 2'b00;
      tick();
      hresetn = 1'b1;
      hready  = 1'b1;
      push(16'h0001, 4'd0, 1'b0);
      tick();
      exp = sb_q.pop_front();
      got = {grant_rr, master_rr, lock_rr};
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL mid_after got=%h want=%h", got, exp);
      end else $display("ok   mid_after state=%h", got);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_lock();
      test_split();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
